// File: rtl/mem_pkg.sv
// Shared encodings and decode helpers for the MEM-stage data-memory access path.
// Opcodes, access-size codes, store/size decode and the alignment rule.
package mem_pkg;

  // Nine operations need a four-bit opcode.
  typedef enum logic [3:0] {
    MEM_LB  = 4'd0,
    MEM_LBU = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LHU = 4'd3,
    MEM_LW  = 4'd4,
    MEM_LWU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  function automatic logic op_is_store(input mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic size_e op_size(input mem_op_e op);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return SZ_H;
      MEM_LW, MEM_LWU, MEM_SW: return SZ_W;
      default:                 return SZ_B;
    endcase
  endfunction

  function automatic logic addr_misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_H:    return addr_lo[0];
      SZ_W:    return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte lane of a bus word and sign/zero-extends it to DATA_W.
// Purely combinational so it can be reused by unaligned-load variants.
module load_extract
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  mem_op_e           op_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] lane;

  // NOTE: every signal driven here gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    lane     = rdata_i >> {offset_i, 3'b000};
    result_o = '0;
    case (op_i)
      MEM_LB:  result_o = DATA_W'($signed(lane[7:0]));
      MEM_LBU: result_o = DATA_W'(lane[7:0]);
      MEM_LH:  result_o = DATA_W'($signed(lane[15:0]));
      MEM_LHU: result_o = DATA_W'(lane[15:0]);
      MEM_LW:  result_o = DATA_W'($signed(lane[31:0]));
      MEM_LWU: result_o = DATA_W'(lane[31:0]);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one access per handshake onto an SRAM-like bus,
// with alignment faults raised before any bus traffic and flush/drain support.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int LANES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  mem_op_e           req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              laddr_err,
  output logic              saddr_err,
  output logic [ADDR_W-1:0] bad_vaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [LANES-1:0]  data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN,
    S_FAULT
  } state_e;

  state_e            state_q;
  mem_op_e           op_q;
  logic [OFF_W-1:0]  off_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              laddr_err_q;
  logic              saddr_err_q;
  logic [ADDR_W-1:0] bad_vaddr_q;
  logic              data_req_q;
  logic              data_wr_q;
  size_e             data_size_q;
  logic [ADDR_W-1:0] data_addr_q;
  logic [LANES-1:0]  data_wstrb_q;
  logic [DATA_W-1:0] data_wdata_q;

  logic [OFF_W-1:0]  req_off;
  size_e             req_size;
  logic              req_store;
  logic              req_misaligned;
  logic [LANES-1:0]  wstrb_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] load_result;
  logic              fault_kill;

  // Decode of the request presented in IDLE: strobes and lane-replicated data.
  always_comb begin
    req_off        = req_addr[OFF_W-1:0];
    req_size       = op_size(req_op);
    req_store      = op_is_store(req_op);
    req_misaligned = addr_misaligned(req_size, req_addr[1:0]);
    wstrb_d        = '0;
    wdata_d        = '0;
    case (req_size)
      SZ_H: begin
        wstrb_d = LANES'(2'b11) << req_off;
        wdata_d = {(LANES / 2){req_wdata[15:0]}};
      end
      SZ_W: begin
        wstrb_d = LANES'(4'hF) << req_off;
        wdata_d = {(LANES / 4){req_wdata[31:0]}};
      end
      default: begin
        wstrb_d = LANES'(1'b1) << req_off;
        wdata_d = {LANES{req_wdata[7:0]}};
      end
    endcase
    if (!req_store) wstrb_d = '0;
  end

  load_extract #(
    .DATA_W (DATA_W)
  ) u_load_extract (
    .op_i     (op_q),
    .offset_i (off_q),
    .rdata_i  (data_rdata),
    .result_o (load_result)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= MEM_LB;
      off_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      laddr_err_q  <= 1'b0;
      saddr_err_q  <= 1'b0;
      bad_vaddr_q  <= '0;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= SZ_B;
      data_addr_q  <= '0;
      data_wstrb_q <= '0;
      data_wdata_q <= '0;
    end else begin
      // Response fields are single-cycle pulses unless set below.
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      laddr_err_q  <= 1'b0;
      saddr_err_q  <= 1'b0;
      bad_vaddr_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && !flush) begin
            op_q         <= req_op;
            off_q        <= req_off;
            data_wr_q    <= req_store;
            data_size_q  <= req_size;
            data_addr_q  <= req_addr;
            data_wstrb_q <= wstrb_d;
            data_wdata_q <= wdata_d;
            req_ready_q  <= 1'b0;
            if (req_misaligned) begin
              state_q      <= S_FAULT;
              resp_valid_q <= 1'b1;
              laddr_err_q  <= !req_store;
              saddr_err_q  <= req_store;
              bad_vaddr_q  <= req_addr;
            end else begin
              state_q    <= S_ADDR;
              data_req_q <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (data_addr_ok) begin
            // Once the address is accepted the bus owes us a data phase.
            data_req_q <= 1'b0;
            state_q    <= flush ? S_DRAIN : S_DATA;
          end else if (flush) begin
            data_req_q  <= 1'b0;
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (data_data_ok) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            if (!flush) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= data_wr_q ? '0 : load_result;
            end
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (data_data_ok) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        S_FAULT: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // A flush during the fault cycle must hide the already-registered response.
  assign fault_kill = (state_q == S_FAULT) && flush;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q && !fault_kill;
  assign resp_rdata = resp_rdata_q;
  assign laddr_err  = laddr_err_q && !fault_kill;
  assign saddr_err  = saddr_err_q && !fault_kill;
  assign bad_vaddr  = bad_vaddr_q;
  assign data_req   = data_req_q;
  assign data_wr    = data_wr_q;
  assign data_size  = data_size_q;
  assign data_addr  = data_addr_q;
  assign data_wstrb = data_wstrb_q;
  assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: 32- and 64-bit units driven in lockstep against a
// transaction-timeline model with directed cases followed by random traffic.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  mem_op_e     req_op = MEM_LB;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [63:0] bus_rdata = '0;

  logic        a_ready, a_resp, a_lerr, a_serr, a_req, a_wr;
  logic [31:0] a_rdata, a_bad, a_addr, a_wdata;
  logic [1:0]  a_size;
  logic [3:0]  a_strb;
  logic        b_ready, b_resp, b_lerr, b_serr, b_req, b_wr;
  logic [63:0] b_rdata, b_wdata;
  logic [31:0] b_bad, b_addr;
  logic [1:0]  b_size;
  logic [7:0]  b_strb;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .flush(flush), .resp_valid(a_resp),
    .resp_rdata(a_rdata), .laddr_err(a_lerr), .saddr_err(a_serr), .bad_vaddr(a_bad),
    .data_req(a_req), .data_wr(a_wr), .data_size(a_size), .data_addr(a_addr),
    .data_wstrb(a_strb), .data_wdata(a_wdata), .data_addr_ok(addr_ok),
    .data_data_ok(data_ok), .data_rdata(bus_rdata[31:0])
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush), .resp_valid(b_resp),
    .resp_rdata(b_rdata), .laddr_err(b_lerr), .saddr_err(b_serr), .bad_vaddr(b_bad),
    .data_req(b_req), .data_wr(b_wr), .data_size(b_size), .data_addr(b_addr),
    .data_wstrb(b_strb), .data_wdata(b_wdata), .data_addr_ok(addr_ok),
    .data_data_ok(data_ok), .data_rdata(bus_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input mem_op_e op);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_LWU, MEM_SW: return 4;
      default:                 return 1;
    endcase
  endfunction

  function automatic bit is_store(input mem_op_e op);
    return op == MEM_SB || op == MEM_SH || op == MEM_SW;
  endfunction

  function automatic bit is_signed_load(input mem_op_e op);
    return op == MEM_LB || op == MEM_LH || op == MEM_LW;
  endfunction

  function automatic logic [63:0] dw_mask(input int dw);
    return (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] exp_load(input int dw, input mem_op_e op,
                                           input logic [31:0] addr, input logic [63:0] rd);
    int          off;
    int          n;
    logic [63:0] field_mask;
    logic [63:0] v;
    off        = int'(addr % (dw / 8));
    n          = nbytes(op);
    field_mask = (n == 4) ? 64'hFFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    v          = ((rd & dw_mask(dw)) >> (8 * off)) & field_mask;
    if (is_signed_load(op) && v[8 * n - 1]) v = v | ~field_mask;
    return v & dw_mask(dw);
  endfunction

  function automatic logic [7:0] exp_strb(input int dw, input int n, input logic [31:0] addr);
    logic [15:0] s;
    s = 16'((1 << n) - 1) << (addr % (dw / 8));
    return s[7:0] & 8'((1 << (dw / 8)) - 1);
  endfunction

  function automatic logic [63:0] exp_wdata(input int dw, input int n, input logic [63:0] wd);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < dw / 8; i++) r[8 * i +: 8] = wd[8 * (i % n) +: 8];
    return r;
  endfunction

  // ---------------- per-cycle expectations ----------------
  logic        check_en = 1'b0;
  logic        e_ready = 1'b1, e_req = 1'b0, e_resp = 1'b0, e_lerr = 1'b0, e_serr = 1'b0, e_wr = 1'b0;
  logic [1:0]  e_size = '0;
  logic [31:0] e_addr = '0, e_bad = '0;
  logic [63:0] e_rd32 = '0, e_rd64 = '0, e_wd32 = '0, e_wd64 = '0;
  logic [7:0]  e_st32 = '0, e_st64 = '0;

  logic        pend = 1'b0;
  logic [63:0] pend_rd32 = '0, pend_rd64 = '0;

  always @(negedge clk) begin
    if (check_en) begin
      check("req_ready32", 64'(a_ready), 64'(e_ready));
      check("req_ready64", 64'(b_ready), 64'(e_ready));
      check("data_req32", 64'(a_req), 64'(e_req));
      check("data_req64", 64'(b_req), 64'(e_req));
      check("resp_valid32", 64'(a_resp), 64'(e_resp));
      check("resp_valid64", 64'(b_resp), 64'(e_resp));
      if (e_req) begin
        check("data_wr32", 64'(a_wr), 64'(e_wr));
        check("data_wr64", 64'(b_wr), 64'(e_wr));
        check("data_size32", 64'(a_size), 64'(e_size));
        check("data_size64", 64'(b_size), 64'(e_size));
        check("data_addr32", 64'(a_addr), 64'(e_addr));
        check("data_addr64", 64'(b_addr), 64'(e_addr));
        if (e_wr) begin
          check("data_wstrb32", 64'(a_strb), 64'(e_st32));
          check("data_wstrb64", 64'(b_strb), 64'(e_st64));
          check("data_wdata32", 64'(a_wdata), e_wd32);
          check("data_wdata64", b_wdata, e_wd64);
        end
      end
      if (e_resp) begin
        check("resp_rdata32", 64'(a_rdata), e_rd32);
        check("resp_rdata64", b_rdata, e_rd64);
        check("laddr_err32", 64'(a_lerr), 64'(e_lerr));
        check("laddr_err64", 64'(b_lerr), 64'(e_lerr));
        check("saddr_err32", 64'(a_serr), 64'(e_serr));
        check("saddr_err64", 64'(b_serr), 64'(e_serr));
        if (e_lerr || e_serr) begin
          check("bad_vaddr32", 64'(a_bad), 64'(e_bad));
          check("bad_vaddr64", 64'(b_bad), 64'(e_bad));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic noise();
    return $urandom_range(0, 3) == 0;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    e_ready   = 1'b0;
    e_req     = 1'b0;
    e_resp    = 1'b0;
    e_lerr    = 1'b0;
    e_serr    = 1'b0;
  endtask

  task automatic set_idle_exp();
    e_ready = 1'b1;
    e_resp  = pend;
    e_rd32  = pend_rd32;
    e_rd64  = pend_rd64;
    pend    = 1'b0;
  endtask

  task automatic idle(input bit flushed_req);
    next_cycle();
    set_idle_exp();
    data_ok = noise();
    if (flushed_req) begin
      req_valid = 1'b1;
      flush     = 1'b1;
      req_op    = MEM_LW;
      req_addr  = $urandom;
    end
  endtask

  // fl_ph: 0 none, 1 flush in ADDR, 2 flush in DATA, 3 flush in FAULT
  task automatic txn(input mem_op_e op, input logic [31:0] addr, input logic [63:0] wd,
                     input logic [63:0] rd, input int a_dly, input int d_dly,
                     input int fl_ph, input int fl_at, input int dr_dly);
    bit st;
    int n;
    int i;
    bit done;
    bit drain;
    st    = is_store(op);
    n     = nbytes(op);
    drain = 1'b0;

    next_cycle();
    set_idle_exp();
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    bus_rdata = rd;
    data_ok   = noise();
    e_wr      = st;
    e_size    = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    e_addr    = addr;
    e_st32    = exp_strb(32, n, addr);
    e_st64    = exp_strb(64, n, addr);
    e_wd32    = exp_wdata(32, n, wd);
    e_wd64    = exp_wdata(64, n, wd);

    if ((addr % n) != 0) begin
      next_cycle();
      flush  = (fl_ph == 3);
      e_resp = (fl_ph != 3);
      e_lerr = !st;
      e_serr = st;
      e_bad  = addr;
      e_rd32 = '0;
      e_rd64 = '0;
      return;
    end

    i    = 0;
    done = 1'b0;
    while (!done) begin
      next_cycle();
      e_req   = 1'b1;
      addr_ok = (i == a_dly);
      data_ok = noise();
      if (fl_ph == 1 && i == fl_at) begin
        flush = 1'b1;
        if (i < a_dly) return;
        drain = 1'b1;
      end
      if (i == a_dly) done = 1'b1;
      i++;
    end

    if (!drain) begin
      i    = 0;
      done = 1'b0;
      while (!done) begin
        next_cycle();
        data_ok = (i == d_dly);
        if (fl_ph == 2 && i == fl_at) begin
          flush = 1'b1;
          if (i == d_dly) return;
          drain = 1'b1;
          done  = 1'b1;
        end else if (i == d_dly) begin
          pend      = 1'b1;
          pend_rd32 = st ? 64'd0 : exp_load(32, op, addr, rd);
          pend_rd64 = st ? 64'd0 : exp_load(64, op, addr, rd);
          return;
        end
        i++;
      end
    end

    for (int k = 0; k <= dr_dly; k++) begin
      next_cycle();
      data_ok = (k == dr_dly);
    end
  endtask

  // ---------------- main sequence ----------------
  mem_op_e     r_op;
  logic [31:0] r_addr;
  logic [63:0] r_wd, r_rd;
  int          r_a, r_d, r_ph, r_at, r_dr;

  initial begin
    // Model pins against hand-computed values.
    check("pin_lb32", exp_load(32, MEM_LB, 32'h1003, 64'h80FF_1234), 64'hFFFF_FF80);
    check("pin_lbu32", exp_load(32, MEM_LBU, 32'h1003, 64'h80FF_1234), 64'h0000_0080);
    check("pin_lh64", exp_load(64, MEM_LH, 32'h4006, 64'h8001_0000_0000_0000), 64'hFFFF_FFFF_FFFF_8001);
    check("pin_lwu64", exp_load(64, MEM_LWU, 32'h4004, 64'hF000_0000_1234_5678), 64'h0000_0000_F000_0000);
    check("pin_strb_sh32", 64'(exp_strb(32, 2, 32'h2002)), 64'hC);
    check("pin_wdata_sh32", exp_wdata(32, 2, 64'hBEEF), 64'hBEEF_BEEF);

    @(posedge clk);
    #1;
    check("rst_ready32", 64'(a_ready), 64'd1);
    check("rst_ready64", 64'(b_ready), 64'd1);
    check("rst_resp32", 64'(a_resp), 64'd0);
    check("rst_req64", 64'(b_req), 64'd0);
    check("rst_rdata32", 64'(a_rdata), 64'd0);
    check("rst_bad64", 64'(b_bad), 64'd0);
    check("rst_strb64", 64'(b_strb), 64'd0);
    check("rst_addr32", 64'(a_addr), 64'd0);
    rst      = 1'b0;
    check_en = 1'b1;
    set_idle_exp();

    // Directed cases.
    txn(MEM_LB, 32'h1003, 64'd0, 64'h80FF_1234, 0, 0, 0, 0, 0);
    txn(MEM_LBU, 32'h1003, 64'd0, 64'h80FF_1234, 0, 0, 0, 0, 0);
    txn(MEM_SH, 32'h2002, 64'h0000_BEEF, 64'd0, 0, 0, 0, 0, 0);
    idle(1'b0);
    txn(MEM_LW, 32'h3001, 64'd0, 64'd0, 0, 0, 0, 0, 0);
    txn(MEM_SW, 32'h3002, 64'd0, 64'd0, 0, 0, 0, 0, 0);
    txn(MEM_LH, 32'h0000_0011, 64'd0, 64'd0, 0, 0, 3, 0, 0);
    txn(MEM_LW, 32'h5000, 64'd0, 64'h1234_5678, 5, 3, 2, 0, 2);
    idle(1'b1);
    txn(MEM_LH, 32'h4006, 64'd0, 64'h8001_0000_0000_0000, 1, 2, 0, 0, 0);
    txn(MEM_LWU, 32'h4004, 64'd0, 64'hF000_0000_1234_5678, 0, 0, 0, 0, 0);
    txn(MEM_SB, 32'h6005, 64'h00A5, 64'd0, 2, 0, 1, 0, 0);
    txn(MEM_SW, 32'h6008, 64'hCAFE_F00D, 64'd0, 2, 1, 1, 2, 1);
    txn(MEM_LHU, 32'h600A, 64'd0, 64'hFFFF_8765_4321_ABCD, 0, 2, 2, 2, 0);
    txn(MEM_LB, 32'h6007, 64'd0, 64'h7F00_0000_0000_0000, 0, 0, 0, 0, 0);

    // Synchronous reset in the middle of a data phase.
    next_cycle();
    set_idle_exp();
    req_valid = 1'b1;
    req_op    = MEM_LW;
    req_addr  = 32'h7000;
    e_wr      = 1'b0;
    e_size    = 2'd2;
    e_addr    = 32'h7000;
    next_cycle();
    e_req   = 1'b1;
    addr_ok = 1'b1;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_idle_exp();

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      r_op   = mem_op_e'($urandom_range(0, 8));
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~32'(nbytes(r_op) - 1);
      r_wd   = {$urandom, $urandom};
      r_rd   = {$urandom, $urandom};
      r_a    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
      r_d    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
      r_ph   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      r_at   = (r_ph == 1) ? $urandom_range(0, r_a) : (r_ph == 2) ? $urandom_range(0, r_d) : 0;
      r_dr   = $urandom_range(0, 3);
      txn(r_op, r_addr, r_wd, r_rd, r_a, r_d, r_ph, r_at, r_dr);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3) == 0);
    end

    next_cycle();
    set_idle_exp();
    next_cycle();
    set_idle_exp();
    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule
